jpeg_mcu_color_sched: RTL
=========================

# jpeg_mcu_color_sched

Scheduler between the IDCT output MCU buffer (ping-pong, signed level-shifted samples) and the YCbCr-to-RGB converter. Per MCU it walks pixels in raster order inside the MCU and generates Y and Cb/Cr buffer read addresses with chroma replication for 4:4:4 / 4:2:2 / 4:2:0. It presents one {Y, Cb, Cr} triple per pixel to the converter, releases each buffer bank when done, and counts MCUs to frame end.

## Interface
Parameters:
- MCU_CNT_W, 16, width of frame MCU counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  frame start pulse; latches subsample_mode and frame_mcus; ignored while busy
- subsample_mode  in  2  0 = 4:4:4, 1 = 4:2:2, 2 = 4:2:0, 3 = treated as 4:4:4
- frame_mcus  in  MCU_CNT_W  MCUs in frame
- busy  out  1  frame in progress
- mcu_valid  in  1  bank rd_bank holds a complete MCU (level)
- mcu_release  out  1  pulse: bank rd_bank consumed
- rd_bank  out  1  bank being read
- y_rd_en  out  1  Y buffer read strobe
- y_rd_addr  out  8  {blk[1:0], row[2:0], col[2:0]}
- c_rd_en  out  1  Cb/Cr buffer read strobe (same address for both)
- c_rd_addr  out  6  {row[2:0], col[2:0]}
- y_rd_data, cb_rd_data, cr_rd_data  in  9 signed each  buffer data, valid 1 cycle after strobe
- pix_ready  in  1  converter accepts an issue this cycle
- pix_valid  out  1  pixel triple valid
- pix_y, pix_cb, pix_cr  out  9 signed each  pass-through of buffer read data
- frame_done  out  1  pulse after last MCU released

## Operation
- States: IDLE, WAIT_MCU, RUN, RELEASE.
- IDLE: start -> latch mode (sub_q) and count; frame_mcus = 0 -> frame_done next cycle, stay IDLE; else -> WAIT_MCU, busy = 1.
- WAIT_MCU: mcu_valid = 1 -> RUN with pixel row r = 0, column c = 0.
- RUN: issue one pixel per cycle when pix_ready = 1; no issue, no counter advance when 0.
- MCU geometry (W x H, pixels): 4:4:4 8x8 = 64, 4:2:2 16x8 = 128, 4:2:0 16x16 = 256. c wraps at W-1 to 0 with r+1.
- Address mapping:
  - 4:4:4: y = {2'b00, r[2:0], c[2:0]}; c_addr = {r[2:0], c[2:0]}
  - 4:2:2: y = {1'b0, c[3], r[2:0], c[2:0]}; c_addr = {r[2:0], c[3:1]}
  - 4:2:0: y = {r[3], c[3], r[2:0], c[2:0]}; c_addr = {r[3:1], c[3:1]}
- y_rd_en = c_rd_en = issue.
- Last pixel issued -> RELEASE.
- RELEASE (one cycle): mcu_release = 1; rd_bank toggles on the next edge; MCU counter decrements. Count reaches 0 -> frame_done pulse same cycle, -> IDLE. Otherwise -> WAIT_MCU.
- pix_y/cb/cr = rd_data combinationally; pix_valid = issue delayed 1 cycle (registered).
- Widths: counters sized to 4 bits r/c, 9-bit MCU pixel counter; no arithmetic overflow possible; MCU counter unsigned, never underflows.

## Timing
- Reset: busy, mcu_release, rd_bank, y_rd_en, c_rd_en, pix_valid, frame_done = 0; addresses 0; state IDLE; sub_q = 0.
- Issue at cycle T -> pix_valid at T+1. Converter must accept the one in-flight pixel after pix_ready falls.
- Earliest first issue: 1 cycle after WAIT_MCU sees mcu_valid.
- Last issue T_L -> RELEASE at T_L+1, coinciding with last pix_valid. Next MCU issue earliest T_L+3 (WAIT_MCU re-samples mcu_valid for the new bank).
- Unstalled MCU occupancy: N + 2 cycles (N = 64/128/256), plus WAIT.
- mcu_valid dropping during RUN: ignored; bank is held until release.
- start during busy: ignored; subsample_mode changes mid-frame have no effect.
- Reset mid-MCU: immediate return to reset values; no release pulse; rd_bank = 0.

## Test plan
- 4:4:4, frame_mcus = 1, pix_ready = 1, buffer preloaded with addr-as-data: 64 pix_valid cycles, y_rd_addr 0..63 in order; mcu_release and frame_done pulse together 1 cycle after last issue.
- 4:2:0 single MCU: pixel (r=9, c=13) issues y_rd_addr = {1,1,001,101} = 0xCD and c_rd_addr = {100,110} = 0x26; exactly 256 pixels; every chroma address appears 4 times.
- 4:2:2 with pix_ready toggling 1,0,1,0: no address skipped or repeated; 128 pix_valid pulses; pix_valid never exceeds issues.
- frame_mcus = 3 with mcu_valid held high: rd_bank sequence 0,1,0,1 across releases; three mcu_release pulses; frame_done only on the third; busy low the cycle after.
- start with frame_mcus = 0: frame_done the next cycle, no read strobes, busy stays 0.
- rst asserted at pixel 40 of a 4:4:4 MCU: all outputs 0 in the same cycle; new start after release runs a full 64-pixel MCU from bank 0.

Source files
------------

// File: rtl/jpeg_mcu_color_sched_if.sv
// Bus between the MCU colour scheduler, the ping-pong sample buffer and the
// YCbCr-to-RGB converter. The scheduler uses the master modport.
interface jpeg_mcu_color_sched_if #(
    parameter int MCU_CNT_W = 16
);
    logic                  start;
    logic [1:0]            subsample_mode;
    logic [MCU_CNT_W-1:0]  frame_mcus;
    logic                  busy;
    logic                  mcu_valid;
    logic                  mcu_release;
    logic                  rd_bank;
    logic                  y_rd_en;
    logic [7:0]            y_rd_addr;
    logic                  c_rd_en;
    logic [5:0]            c_rd_addr;
    logic signed [8:0]     y_rd_data;
    logic signed [8:0]     cb_rd_data;
    logic signed [8:0]     cr_rd_data;
    logic                  pix_ready;
    logic                  pix_valid;
    logic signed [8:0]     pix_y;
    logic signed [8:0]     pix_cb;
    logic signed [8:0]     pix_cr;
    logic                  frame_done;

    modport master (
        input  start, subsample_mode, frame_mcus, mcu_valid,
               y_rd_data, cb_rd_data, cr_rd_data, pix_ready,
        output busy, mcu_release, rd_bank, y_rd_en, y_rd_addr, c_rd_en,
               c_rd_addr, pix_valid, pix_y, pix_cb, pix_cr, frame_done
    );

    modport slave (
        output start, subsample_mode, frame_mcus, mcu_valid,
               y_rd_data, cb_rd_data, cr_rd_data, pix_ready,
        input  busy, mcu_release, rd_bank, y_rd_en, y_rd_addr, c_rd_en,
               c_rd_addr, pix_valid, pix_y, pix_cb, pix_cr, frame_done
    );
endinterface

// File: rtl/jpeg_mcu_color_sched.sv
// Walks each MCU in raster order, generating Y and chroma buffer addresses with
// 4:4:4 / 4:2:2 / 4:2:0 chroma replication, and releases buffer banks per MCU.
module jpeg_mcu_color_sched #(
    parameter int MCU_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    jpeg_mcu_color_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MCU, RUN, RELEASE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sub_q, sub_d;
    logic [MCU_CNT_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic [3:0]           row_q, row_d;
    logic [3:0]           col_q, col_d;
    logic [8:0]           pix_cnt_q, pix_cnt_d;
    logic                 bank_q, bank_d;
    logic                 pix_valid_q;
    logic                 zero_done_q, zero_done_d;

    logic                 issue;
    logic                 release_pulse;
    logic                 last_done;
    logic [3:0]           col_max;
    logic [8:0]           pix_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sub_q       <= 2'd0;
            mcu_cnt_q   <= '0;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            pix_cnt_q   <= 9'd0;
            bank_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            mcu_cnt_q   <= mcu_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pix_cnt_q   <= pix_cnt_d;
            bank_q      <= bank_d;
            pix_valid_q <= issue;
            zero_done_q <= zero_done_d;
        end
    end

    // sub_q only ever holds 0..2, so mode 3 falls into the 4:4:4 defaults.
    always_comb begin
        col_max  = 4'd7;
        pix_last = 9'd63;
        case (sub_q)
            2'd1: begin col_max = 4'd15; pix_last = 9'd127; end
            2'd2: begin col_max = 4'd15; pix_last = 9'd255; end
            default: ;
        endcase
    end

    assign issue = (state_q == RUN) && bus.pix_ready;

    always_comb begin
        state_d       = state_q;
        sub_d         = sub_q;
        mcu_cnt_d     = mcu_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        pix_cnt_d     = pix_cnt_q;
        bank_d        = bank_q;
        zero_done_d   = 1'b0;
        release_pulse = 1'b0;
        last_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sub_d     = (bus.subsample_mode == 2'd3) ? 2'd0 : bus.subsample_mode;
                    mcu_cnt_d = bus.frame_mcus;
                    if (bus.frame_mcus == '0) zero_done_d = 1'b1;
                    else                      state_d     = WAIT_MCU;
                end
            end
            WAIT_MCU: begin
                if (bus.mcu_valid) begin
                    state_d   = RUN;
                    row_d     = 4'd0;
                    col_d     = 4'd0;
                    pix_cnt_d = 9'd0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (pix_cnt_q == pix_last) begin
                        state_d   = RELEASE;
                        row_d     = 4'd0;
                        col_d     = 4'd0;
                        pix_cnt_d = 9'd0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 9'd1;
                        if (col_q == col_max) begin
                            col_d = 4'd0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                end
            end
            RELEASE: begin
                release_pulse = 1'b1;
                bank_d        = ~bank_q;
                mcu_cnt_d     = mcu_cnt_q - MCU_CNT_W'(1);
                if (mcu_cnt_q == MCU_CNT_W'(1)) begin
                    last_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = WAIT_MCU;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wide modes pick the 8x8 luma block from the high row/column bits.
    always_comb begin
        bus.y_rd_addr = {2'b00, row_q[2:0], col_q[2:0]};
        bus.c_rd_addr = {row_q[2:0], col_q[2:0]};
        case (sub_q)
            2'd1: begin
                bus.y_rd_addr = {1'b0, col_q[3], row_q[2:0], col_q[2:0]};
                bus.c_rd_addr = {row_q[2:0], col_q[3:1]};
            end
            2'd2: begin
                bus.y_rd_addr = {row_q[3], col_q[3], row_q[2:0], col_q[2:0]};
                bus.c_rd_addr = {row_q[3:1], col_q[3:1]};
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.mcu_release = release_pulse;
    assign bus.rd_bank     = bank_q;
    assign bus.y_rd_en     = issue;
    assign bus.c_rd_en     = issue;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_y       = bus.y_rd_data;
    assign bus.pix_cb      = bus.cb_rd_data;
    assign bus.pix_cr      = bus.cr_rd_data;
    assign bus.frame_done  = last_done | zero_done_q;
endmodule
